uart_frame_ctrl: RTL
====================

# uart_frame_ctrl

Frame-level controller between the byte-level UART receiver and the register/config consumers. It consumes received bytes, hunts for the 0xFA 0xFB header and collects a fixed-length frame. It checks the 0xFC 0xFD tail and enforces an inter-byte gap timeout. Validated frames are presented through a valid/ack handshake, and `rx_en` gates the receiver while a frame is held.

## Interface
- FRAME_BYTES, 48, total frame length in bytes including header and tail (min 6)
- GAP_CYC, 20000, max clk cycles between accepted bytes inside a frame before abort
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, `rx_byte` valid
- rx_byte  in  8  received byte
- rx_en  out  1  receiver enable; high in HUNT/HDR/BODY
- frame_valid  out  1  held frame available
- frame_data  out  FRAME_BYTES*8  frame; byte 0 (0xFA) at MSB, last byte (0xFD) at [7:0]
- frame_ack  in  1  consumer accepts frame
- err_code  out  2  last error: 0 none, 1 tail, 2 checksum, 3 timeout
- err_cnt  out  8  saturating error count
- busy  out  1  state != HUNT

## Operation
- States: HUNT, HDR, BODY, CHECK, HOLD. Reset -> HUNT.
- HUNT: on rx_valid with byte==0xFA -> HDR. Store the byte at index 0 and set idx=1. Other bytes are discarded.
- HDR: on rx_valid:
  - 0xFB: store at index 1, set idx=2, go to BODY.
  - 0xFA: stay in HDR.
  - anything else: go to HUNT; no error is recorded.
- BODY: each rx_valid stores the byte at index idx and increments idx. When the byte at index FRAME_BYTES-1 is stored -> CHECK.
- CHECK (one cycle), in priority order:
  - Bytes FRAME_BYTES-2/-1 != 0xFC/0xFD: err_code=1, go to HUNT.
  - Checksum fails (macro builds only): err_code=2, go to HUNT.
  - Otherwise copy the capture buffer to frame_data, set frame_valid=1, go to HOLD.
- HOLD: rx_en=0 and rx_valid is ignored. When frame_ack is sampled high, clear frame_valid and go to HUNT. frame_data keeps its value until the next good frame.
- Gap timer: cleared on every accepted byte and counts in HDR/BODY. Reaching GAP_CYC-1 with no rx_valid: err_code=3, go to HUNT.
- err_cnt increments on each error, saturates at 255, and is cleared only by rst. err_code holds its value until the next error.
- A bad frame never modifies frame_data.
- idx width is clog2(FRAME_BYTES). Bytes are stored by index; no shift chain is used.

## Timing
- Reset values: rx_en=1, frame_valid=0, frame_data=0, err_code=0, err_cnt=0, busy=0, state=HUNT.
- Last byte sampled in cycle N -> CHECK in cycle N+1 -> frame_valid=1 and new frame_data visible in cycle N+2.
- rx_en drops in cycle N+1. It returns in the cycle after ack is sampled, or the cycle after an error in CHECK.
- frame_ack sampled high in cycle M -> frame_valid=0 and state HUNT in cycle M+1. frame_ack outside HOLD is ignored.
- Timeout: abort in the cycle the counter reaches GAP_CYC-1. If rx_valid arrives in that same cycle, the byte wins and the timer clears.
- err_cnt/err_code update in the cycle after CHECK or after the timeout.
- rst is asserted mid-frame or in HOLD: all state returns to reset values on the next edge. A held frame is lost.

## Configuration
- UART_FRAME_CHKSUM_EN defined:
  - Byte FRAME_BYTES-3 is the checksum, equal to the 8-bit modulo sum of bytes 0..FRAME_BYTES-4.
  - On mismatch -> err_code=2.
  - The checksum is accumulated as bytes arrive, not in CHECK.
- Undefined: no checksum logic; byte FRAME_BYTES-3 is ordinary payload. err_code value 2 is never produced.

## Structure
- Package `uart_frame_pkg`:
  - State enum.
  - Constants HDR0=8'hFA, HDR1=8'hFB, TL0=8'hFC, TL1=8'hFD.
  - err_code encodings.
- Sub-module `uart_gap_timer`: parameter GAP_CYC; inputs clk, rst, run, kick; output expire pulse.
- Capture buffer and FSM stay in the top module.

## Test plan
- Good 48-byte frame (FA FB, payload 0x01..0x2C, FC FD; checksum-correct when built with the macro) -> frame_valid at N+2. frame_data[383:376]=0xFA, [7:0]=0xFD. rx_en=0 until ack. After ack, frame_valid=0 one cycle later.
- Tail corrupted to FC FE -> no frame_valid, err_code=1, err_cnt=1, frame_data unchanged from the prior good frame.
- Leading junk "00 FA FA FB ..." followed by a good frame -> frame accepted, err_cnt=0.
- Byte gap of GAP_CYC cycles after byte 10 -> HUNT, err_code=3. A subsequent good frame is accepted.
- Good frame, no ack, 10 extra bytes driven -> frame_valid stays 1, frame_data unchanged, extra bytes ignored.
- With UART_FRAME_CHKSUM_EN, checksum byte wrong -> err_code=2. rst pulsed at byte 20 -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// ============================================================================
// Module      : uart_frame_pkg
// Description : Shared state encoding, framing constants and error codes for
//               the UART frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_HDR   = 3'd1,
    ST_BODY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam logic [7:0] HDR0 = 8'hFA;
  localparam logic [7:0] HDR1 = 8'hFB;
  localparam logic [7:0] TL0  = 8'hFC;
  localparam logic [7:0] TL1  = 8'hFD;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TAIL    = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/uart_gap_timer.sv
// ============================================================================
// Module      : uart_gap_timer
// Description : Inter-byte gap watchdog; pulses expire when GAP_CYC-1 idle
//               cycles elapse while run is high. A kick in the same cycle wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_gap_timer #(
  parameter int GAP_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expire
);

  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic [CW-1:0] cnt_q;

  assign expire = run && !kick && (cnt_q == CW'(GAP_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || kick || !run) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
// ============================================================================
// Module      : uart_frame_ctrl
// Description : Header hunt, fixed-length frame capture, tail/gap checking and
//               valid/ack hand-off. Define UART_FRAME_CHKSUM_EN to add the
//               8-bit additive checksum in byte FRAME_BYTES-3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 48,
  parameter int GAP_CYC     = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  output logic                     rx_en,
  output logic                     frame_valid,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  input  logic                     frame_ack,
  output logic [1:0]               err_code,
  output logic [7:0]               err_cnt,
  output logic                     busy
);

  localparam int IDXW = $clog2(FRAME_BYTES);

  state_e                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d, store_idx;
  logic                     store, load, err_set, expire, tail_bad, chk_bad;
  logic [1:0]               err_val;
  logic [7:0]               buf_q [FRAME_BYTES];
  logic [FRAME_BYTES*8-1:0] frame_q;
  logic [1:0]               err_code_q;
  logic [7:0]               err_cnt_q;

  assign rx_en       = (state_q == ST_HUNT) || (state_q == ST_HDR) || (state_q == ST_BODY);
  assign busy        = (state_q != ST_HUNT);
  assign frame_valid = (state_q == ST_HOLD);
  assign frame_data  = frame_q;
  assign err_code    = err_code_q;
  assign err_cnt     = err_cnt_q;

  assign tail_bad = (buf_q[FRAME_BYTES-2] != TL0) || (buf_q[FRAME_BYTES-1] != TL1);

  uart_gap_timer #(.GAP_CYC(GAP_CYC)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .run    ((state_q == ST_HDR) || (state_q == ST_BODY)),
    .kick   (rx_valid && rx_en),
    .expire (expire)
  );

`ifdef UART_FRAME_CHKSUM_EN
  // Running sum over bytes 0..FRAME_BYTES-4 so CHECK only needs one compare.
  logic [7:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (store) begin
      if (store_idx == '0) begin
        sum_q <= rx_byte;
      end else if (store_idx < IDXW'(FRAME_BYTES - 3)) begin
        sum_q <= sum_q + rx_byte;
      end
    end
  end

  assign chk_bad = (sum_q != buf_q[FRAME_BYTES-3]);
`else
  assign chk_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    store     = 1'b0;
    store_idx = idx_q;
    load      = 1'b0;
    err_set   = 1'b0;
    err_val   = ERR_NONE;
    case (state_q)
      ST_HUNT: begin
        if (rx_valid && rx_byte == HDR0) begin
          store     = 1'b1;
          store_idx = '0;
          idx_d     = IDXW'(1);
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (expire) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end else if (rx_valid) begin
          if (rx_byte == HDR1) begin
            store     = 1'b1;
            store_idx = IDXW'(1);
            idx_d     = IDXW'(2);
            state_d   = ST_BODY;
          end else if (rx_byte != HDR0) begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_BODY: begin
        if (expire) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
          state_d = ST_HUNT;
        end else if (rx_valid) begin
          store = 1'b1;
          idx_d = idx_q + IDXW'(1);
          if (idx_q == IDXW'(FRAME_BYTES - 1)) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_HUNT;
        if (tail_bad) begin
          err_set = 1'b1;
          err_val = ERR_TAIL;
        end else if (chk_bad) begin
          err_set = 1'b1;
          err_val = ERR_CHKSUM;
        end else begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_ack) begin
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Capture buffer is indexed storage; stale bytes are always overwritten
  // before CHECK reads them, so it needs no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      buf_q[store_idx] <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      err_code_q <= ERR_NONE;
      err_cnt_q  <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < FRAME_BYTES; i++) begin
          frame_q[(FRAME_BYTES-1-i)*8 +: 8] <= buf_q[i];
        end
      end
      if (err_set) begin
        err_code_q <= err_val;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
